// File: rtl/ram_bist_ctrl.sv
// BIST sequencer for a simple dual-port block RAM: writes a pattern through port A,
// reads it back through port B and reports the mismatch count and the first failing location.
module ram_bist_ctrl #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 16,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        pattern_sel,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;
    logic [1:0]          pat_sel_q, pat_sel_d;
    logic [1:0]          drain_q, drain_d;
    logic [RD_LATENCY:0] vld_q, vld_d;
    logic [DATA_W-1:0]   exp_p [RD_LATENCY+1];
    logic [ADDR_W-1:0]   tag_p [RD_LATENCY+1];
    logic                mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ax;
        logic [DATA_W-1:0] alt;
        ax = DATA_W'(a);
        for (int i = 0; i < DATA_W; i++) begin
            alt[i] = a[0] ^ (i % 2 == 0);
        end
        case (sel)
            2'd0:    pattern = SEED + ax;
            2'd1:    pattern = ax;
            2'd2:    pattern = alt;
            default: pattern = ~(SEED + ax);
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        wea_d       = wea_q;
        addra_d     = addra_q;
        dina_d      = dina_q;
        addrb_d     = addrb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        pat_sel_d   = pat_sel_q;
        drain_d     = drain_q;
        vld_d       = {vld_q[RD_LATENCY-1:0], 1'b0};

        // Last pipeline stage lines up with ram_doutb for the address it carries
        mismatch = vld_q[RD_LATENCY] && (ram_doutb != exp_p[RD_LATENCY]);
        if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
                ferr_addr_d = tag_p[RD_LATENCY];
                ferr_data_d = ram_doutb;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_WRITE;
                    busy_d      = 1'b1;
                    wea_d       = 1'b1;
                    addra_d     = '0;
                    dina_d      = pattern(pattern_sel, '0);
                    pat_sel_d   = pattern_sel;
                    err_cnt_d   = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_WRITE: begin
                if (addra_q == LAST_ADDR) begin
                    state_d  = S_READ;
                    wea_d    = 1'b0;
                    addrb_d  = '0;
                    vld_d[0] = 1'b1;
                end else begin
                    addra_d = addra_q + 1'b1;
                    dina_d  = pattern(pat_sel_q, addra_q + 1'b1);
                end
            end
            S_READ: begin
                if (addrb_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    addrb_d  = addrb_q + 1'b1;
                    vld_d[0] = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops in-flight reads but keeps whatever errors were already counted
        if (abort && (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN)) begin
            state_d = S_IDLE;
            wea_d   = 1'b0;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
            vld_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            addrb_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            pat_sel_q   <= '0;
            drain_q     <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            addrb_q     <= addrb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            pat_sel_q   <= pat_sel_d;
            drain_q     <= drain_d;
            vld_q       <= vld_d;
        end
    end

    // Expected-data pipeline: stage 0 matches the address being issued on port B
    always_ff @(posedge clk) begin
        exp_p[0] <= pattern(pat_sel_q, addrb_d);
        tag_p[0] <= addrb_d;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            exp_p[i] <= exp_p[i-1];
            tag_p[i] <= tag_p[i-1];
        end
    end

    assign ram_wea        = wea_q;
    assign ram_addra      = addra_q;
    assign ram_dina       = dina_q;
    assign ram_addrb      = addrb_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: default instance plus a small ADDR_W=4 / RD_LATENCY=2 instance,
// each driving a behavioural RAM with optional read corruption.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default-parameter instance
    logic        start = 1'b0, abort = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        wea, busy, done, pass;
    logic [8:0]  addra, addrb, ferr_addr;
    logic [15:0] dina, doutb, ferr_data;
    logic [9:0]  err_cnt;

    // Small instance
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [1:0]  pattern_sel2 = 2'd0;
    logic        wea2, busy2, done2, pass2;
    logic [3:0]  addra2, addrb2, ferr_addr2;
    logic [15:0] dina2, doutb2, ferr_data2;
    logic [4:0]  err_cnt2;

    // Read corruption controls for the default RAM
    logic        bad_en = 1'b0;
    logic [8:0]  bad_a = '0, bad_b = '0;
    logic [15:0] bad_mask = '0;

    int n_cmp = 0;
    int n_err = 0;

    ram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_sel(pattern_sel),
        .ram_wea(wea), .ram_addra(addra), .ram_dina(dina), .ram_addrb(addrb), .ram_doutb(doutb),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(ferr_addr), .first_err_data(ferr_data)
    );

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(16), .RD_LATENCY(2), .SEED(16'd0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .pattern_sel(pattern_sel2),
        .ram_wea(wea2), .ram_addra(addra2), .ram_dina(dina2), .ram_addrb(addrb2), .ram_doutb(doutb2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_addr(ferr_addr2), .first_err_data(ferr_data2)
    );

    logic [15:0] mem1 [512];
    logic [15:0] mem2 [16];
    logic [15:0] rd2_s1;

    always @(posedge clk) begin
        if (wea) mem1[addra] <= dina;
        doutb <= mem1[addrb] ^ ((bad_en && (addrb == bad_a || addrb == bad_b)) ? bad_mask : 16'h0000);
    end

    always @(posedge clk) begin
        if (wea2) mem2[addra2] <= dina2;
        rd2_s1 <= mem2[addrb2];
        doutb2 <= rd2_s1;
    end

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] pat1(input logic [1:0] sel, input logic [8:0] a);
        case (sel)
            2'd0:    pat1 = 16'(a) + 16'd1;
            2'd1:    pat1 = 16'(a);
            2'd2:    pat1 = a[0] ? 16'hAAAA : 16'h5555;
            default: pat1 = ~(16'(a) + 16'd1);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one test on the default instance. Cycle c is the cycle after edge E(c), E0 = start edge.
    task automatic run1(input logic [1:0] sel, input int restart_at, input int abort_at,
                        output int done_cyc, output int ndone, output int nwr);
        logic [24:0] wq[$];
        logic [24:0] w;
        done_cyc = -1;
        ndone    = 0;
        nwr      = 0;
        for (int a = 0; a < 512; a++) wq.push_back({9'(a), pat1(sel, 9'(a))});
        pattern_sel = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cnt_cleared", err_cnt, 0);
        for (int c = 0; c < 1200; c++) begin
            if (wea) begin
                nwr++;
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("addra", addra, w[24:16]);
                    check("dina", dina, w[15:0]);
                end
            end
            if (abort_at < 0 && c >= 512 && c < 1024) check("addrb", addrb, c - 512);
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                check("abort_busy", busy, 0);
                check("abort_wea", wea, 0);
                check("abort_pass", pass, 0);
            end
            start = (c == restart_at);
            abort = (c == abort_at);
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            if (abort_at >= 0 && c >= abort_at + 6) break;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at < 0) check("writes_left", wq.size(), 0);
    endtask

    initial begin
        int dc, nd, nw;
        logic [15:0] q2[$];
        int dc2;
        dc = 0; nd = 0; nw = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wea", wea, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_addrb", addrb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ferr_addr", ferr_addr, 0);
        check("rst_ferr_data", ferr_data, 0);
        check("rst2_wea", wea2, 0);
        check("rst2_busy", busy2, 0);
        rst = 1'b0;
        tick();

        // Incrementing pattern, clean RAM
        run1(2'd0, -1, -1, dc, nd, nw);
        check("t1_done_cycle", dc, 1025);
        check("t1_done_count", nd, 1);
        check("t1_writes", nw, 512);
        check("t1_pass", pass, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_busy_after", busy, 0);
        check("t1_addra_hold", addra, 511);
        repeat (3) tick();
        check("t1_pass_hold", pass, 1);

        // start pulsed again during WRITE is ignored
        run1(2'd0, 100, -1, dc, nd, nw);
        check("t4_done_cycle", dc, 1025);
        check("t4_done_count", nd, 1);
        check("t4_writes", nw, 512);
        check("t4_pass", pass, 1);

        // Single corrupted address, address pattern
        bad_en = 1'b1; bad_a = 9'd37; bad_b = 9'd37; bad_mask = 16'h0008;
        run1(2'd1, -1, -1, dc, nd, nw);
        check("t2_done_cycle", dc, 1025);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_ferr_addr", ferr_addr, 37);
        check("t2_ferr_data", ferr_data, 16'h002D);
        check("t2_pass", pass, 0);

        // Two corrupted addresses, alternating pattern
        bad_a = 9'd5; bad_b = 9'd200; bad_mask = 16'h0001;
        run1(2'd2, -1, -1, dc, nd, nw);
        check("t3_err_cnt", err_cnt, 2);
        check("t3_ferr_addr", ferr_addr, 5);
        check("t3_ferr_data", ferr_data, 16'hAAAB);
        check("t3_pass", pass, 0);

        // Abort in READ: no done, partial error state kept
        run1(2'd2, -1, 600, dc, nd, nw);
        check("t5_done_count", nd, 0);
        check("t5_busy", busy, 0);
        check("t5_pass", pass, 0);
        check("t5_partial_err_cnt", err_cnt, 1);
        check("t5_partial_ferr_addr", ferr_addr, 5);
        bad_en = 1'b0;

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_wea", wea, 0);

        // Asynchronous reset mid-WRITE
        pattern_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("pre_rst_wea", wea, 1);
        check("pre_rst_addra", addra, 50);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wea", wea, 0);
        check("async_rst_addra", addra, 0);
        check("async_rst_dina", dina, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_pass", pass, 0);
        check("async_rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Small instance: inverted pattern with SEED=0, two-cycle read latency
        for (int a = 0; a < 16; a++) q2.push_back(~16'(a));
        dc2 = -1;
        pattern_sel2 = 2'd3;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (wea2 && q2.size() > 0) check("t6_dina", dina2, q2.pop_front());
            if (done2 && dc2 < 0) dc2 = c;
            if (dc2 >= 0) break;
            tick();
        end
        check("t6_writes_left", q2.size(), 0);
        check("t6_done_cycle", dc2, 34);
        check("t6_pass", pass2, 1);
        check("t6_err_cnt", err_cnt2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
